// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that time-shares one binary (Stein) GCD engine among NREQ requesters.
// Optional per-requester response counters are built when GCD_STATS_EN is defined.
`ifdef GCD_STATS_EN
module gcd_rr_stat_lane (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inc,
    output logic [15:0] o_cnt
);
    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_cnt = r_cnt;
endmodule
`endif

module gcd_rr_scheduler #(
    parameter  int LEN  = 8,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*LEN-1:0]  i_req_a,
    input  logic [NREQ*LEN-1:0]  i_req_b,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [LEN-1:0]       o_rsp_hcf,
    output logic                 o_busy
`ifdef GCD_STATS_EN
    ,
    output logic [NREQ*16-1:0]   o_stat_cnt
`endif
);
    localparam int KW = $clog2(LEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [IDW-1:0]           r_rr_ptr, w_rr_ptr_nxt;
    logic [IDW-1:0]           r_id, w_id_nxt;
    logic [LEN-1:0]           r_a, w_a_nxt;
    logic [LEN-1:0]           r_b, w_b_nxt;
    logic [KW-1:0]            r_k, w_k_nxt;
    logic                     r_rsp_valid, w_rsp_valid_nxt;
    logic [IDW-1:0]           r_rsp_id, w_rsp_id_nxt;
    logic [LEN-1:0]           r_rsp_hcf, w_rsp_hcf_nxt;

    logic [NREQ-1:0][LEN-1:0] w_a_lane, w_b_lane;
    logic [IDW-1:0]           w_scan;
    logic [IDW-1:0]           w_grant;
    logic                     w_grant_vld;
    logic [NREQ-1:0]          w_req_ready;
    logic                     w_rsp_hs;

    assign w_a_lane = i_req_a;
    assign w_b_lane = i_req_b;

    // Scan from the farthest offset down so the nearest valid requester after rr_ptr wins.
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        w_scan      = '0;
        for (int off = NREQ; off >= 1; off--) begin
            w_scan = IDW'((int'(r_rr_ptr) + off) % NREQ);
            if (i_req_valid[w_scan]) begin
                w_grant     = w_scan;
                w_grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if ((r_state == S_IDLE) && w_grant_vld) begin
            w_req_ready[w_grant] = 1'b1;
        end
    end

    assign w_rsp_hs = (r_state == S_DONE) && r_rsp_valid && i_rsp_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_id_nxt        = r_id;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_k_nxt         = r_k;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_id_nxt    = r_rsp_id;
        w_rsp_hcf_nxt   = r_rsp_hcf;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_a_nxt      = w_a_lane[w_grant];
                    w_b_nxt      = w_b_lane[w_grant];
                    w_k_nxt      = '0;
                    w_id_nxt     = w_grant;
                    w_rr_ptr_nxt = w_grant;
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                if ((r_a == '0) || (r_b == '0) || (r_a == r_b)) begin
                    // Result never exceeds the larger operand, so truncation loses nothing.
                    w_rsp_hcf_nxt   = (r_a | r_b) << r_k;
                    w_rsp_id_nxt    = r_id;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end else if (!r_a[0] && !r_b[0]) begin
                    w_a_nxt = r_a >> 1;
                    w_b_nxt = r_b >> 1;
                    w_k_nxt = r_k + KW'(1);
                end else if (r_a[0] && !r_b[0]) begin
                    w_b_nxt = r_b >> 1;
                end else if (!r_a[0] && r_b[0]) begin
                    w_a_nxt = r_a >> 1;
                end else if (r_a >= r_b) begin
                    w_a_nxt = (r_a - r_b) >> 1;
                end else begin
                    w_b_nxt = (r_b - r_a) >> 1;
                end
            end
            S_DONE: begin
                if (w_rsp_hs) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_k         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_hcf   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_id        <= w_id_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_k         <= w_k_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_id    <= w_rsp_id_nxt;
            r_rsp_hcf   <= w_rsp_hcf_nxt;
        end
    end

    assign o_req_ready = w_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_hcf   = r_rsp_hcf;
    assign o_busy      = (r_state != S_IDLE);

`ifdef GCD_STATS_EN
    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        gcd_rr_stat_lane u_stat (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_inc   (w_rsp_hs && (r_rsp_id == IDW'(g))),
            .o_cnt   (o_stat_cnt[g*16 +: 16])
        );
    end
`endif
endmodule
